// File: rtl/dsp_pkg.sv
// Shared constants for the DSP slice post-adder: operand select codes,
// OPMODE bit positions and datapath widths.
package dsp_pkg;

    localparam int unsigned P_W = 48;
    localparam int unsigned M_W = 36;

    localparam logic [1:0] X_ZERO = 2'd0;
    localparam logic [1:0] X_M    = 2'd1;
    localparam logic [1:0] X_P    = 2'd2;
    localparam logic [1:0] X_DAB  = 2'd3;

    localparam logic [1:0] Z_ZERO = 2'd0;
    localparam logic [1:0] Z_PCIN = 2'd1;
    localparam logic [1:0] Z_P    = 2'd2;
    localparam logic [1:0] Z_C    = 2'd3;

    localparam int unsigned OP_SUB = 7;
    localparam int unsigned OP_CIN = 5;

endpackage

// File: rtl/dsp_pipe_reg.sv
// Width-parameterised pipeline register with clock enable, asynchronous
// active-high reset and an optional combinational bypass.
module dsp_pipe_reg #(
    parameter int unsigned W       = 1,
    parameter bit          USE_REG = 1'b1
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         ce,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            q_reg <= '0;
        end else if (ce) begin
            q_reg <= d;
        end
    end

    assign q = USE_REG ? q_reg : d;

endmodule

// File: rtl/dsp_post_adder_acc.sv
// DSP slice final stage: opmode-selected X/Z operands, 48-bit add/subtract
// with carry-in, and the P accumulator register.
module dsp_post_adder_acc
    import dsp_pkg::*;
#(
    parameter bit    PREG        = 1'b1,
    parameter bit    CARRYOUTREG = 1'b1,
    parameter bit    OPMODEREG   = 1'b1,
    parameter bit    CARRYINREG  = 1'b1,
    parameter string CARRYINSEL  = "OPMODE5"
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           CEP,
    input  logic           CEOPMODE,
    input  logic           CECARRYIN,
    input  logic [7:0]     OPMODE,
    input  logic [M_W-1:0] M,
    input  logic [P_W-1:0] DAB,
    input  logic [P_W-1:0] C,
    input  logic [P_W-1:0] PCIN,
    input  logic           CARRYIN,
    output logic [P_W-1:0] P,
    output logic [P_W-1:0] PCOUT,
    output logic           CARRYOUT,
    output logic           CARRYOUTF
);

    logic [7:0]     op;
    logic           cin_raw;
    logic           ci;
    logic [P_W-1:0] x_mux;
    logic [P_W-1:0] z_mux;
    logic [P_W:0]   result;
    logic [P_W-1:0] sum;
    logic           co;
    logic [P_W-1:0] p_r;
    logic           cout_q;
    logic           unused_bits;

    generate
        if (CARRYINSEL == "CARRYIN") begin : g_cin_port
            assign cin_raw = CARRYIN;
        end else if (CARRYINSEL == "OPMODE5") begin : g_cin_opmode
            assign cin_raw = OPMODE[OP_CIN];
        end else begin : g_cin_bad
            $error("dsp_post_adder_acc: CARRYINSEL must be \"OPMODE5\" or \"CARRYIN\"");
            assign cin_raw = 1'b0;
        end
    endgenerate

    assign unused_bits = ^{op[6], op[4], CARRYIN};

    dsp_pipe_reg #(.W(8), .USE_REG(OPMODEREG)) u_opmode_reg (
        .CLK (CLK),
        .RST (RST),
        .ce  (CEOPMODE),
        .d   (OPMODE),
        .q   (op)
    );

    // Carry-in is captured from the raw OPMODE bit, so it lines up with the
    // opmode register when both are enabled.
    dsp_pipe_reg #(.W(1), .USE_REG(CARRYINREG)) u_cin_reg (
        .CLK (CLK),
        .RST (RST),
        .ce  (CECARRYIN),
        .d   (cin_raw),
        .q   (ci)
    );

    always_comb begin
        x_mux = '0;
        case (op[1:0])
            X_ZERO:  x_mux = '0;
            X_M:     x_mux = {{(P_W-M_W){1'b0}}, M};
            X_P:     x_mux = p_r;
            X_DAB:   x_mux = DAB;
            default: x_mux = '0;
        endcase
    end

    always_comb begin
        z_mux = '0;
        case (op[3:2])
            Z_ZERO:  z_mux = '0;
            Z_PCIN:  z_mux = PCIN;
            Z_P:     z_mux = p_r;
            Z_C:     z_mux = C;
            default: z_mux = '0;
        endcase
    end

    always_comb begin
        result = '0;
        if (op[OP_SUB]) begin
            result = {1'b0, z_mux} - ({1'b0, x_mux} + {{P_W{1'b0}}, ci});
        end else begin
            result = {1'b0, z_mux} + {1'b0, x_mux} + {{P_W{1'b0}}, ci};
        end
    end

    assign sum = result[P_W-1:0];
    assign co  = result[P_W];

    // The accumulator is always registered: feedback must come from p_r even
    // when P itself is presented combinationally.
    dsp_pipe_reg #(.W(P_W), .USE_REG(1'b1)) u_p_reg (
        .CLK (CLK),
        .RST (RST),
        .ce  (CEP),
        .d   (sum),
        .q   (p_r)
    );

    dsp_pipe_reg #(.W(1), .USE_REG(CARRYOUTREG)) u_cout_reg (
        .CLK (CLK),
        .RST (RST),
        .ce  (CEP),
        .d   (co),
        .q   (cout_q)
    );

    assign P         = PREG ? p_r : sum;
    assign PCOUT     = P;
    assign CARRYOUT  = cout_q;
    assign CARRYOUTF = cout_q;

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// Bench for dsp_post_adder_acc: a fully registered instance and a bypassed
// instance share stimulus and are checked against an arithmetic model.
module tb_dsp_post_adder_acc;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CEP = 1'b1;
    logic        CEOPMODE = 1'b1;
    logic        CECARRYIN = 1'b1;
    logic [7:0]  OPMODE = 8'h00;
    logic [35:0] M = '0;
    logic [47:0] DAB = '0;
    logic [47:0] C = '0;
    logic [47:0] PCIN = '0;
    logic        CARRYIN = 1'b0;

    logic [47:0] p_a, pcout_a, p_b, pcout_b;
    logic        co_a, cof_a, co_b, cof_b;

    int checks = 0;
    int failures = 0;
    bit started = 1'b0;

    // Model state: registered instance A and bypassed instance B
    logic [47:0] ma_p = '0;
    logic        ma_co = 1'b0;
    logic [7:0]  ma_op = '0;
    logic        ma_ci = 1'b0;
    logic [47:0] mb_p = '0;
    logic        mb_co = 1'b0;
    logic        mb_ci = 1'b0;

    always #5 CLK = ~CLK;

    dsp_post_adder_acc dut_a (
        .CLK(CLK), .RST(RST), .CEP(CEP), .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN),
        .OPMODE(OPMODE), .M(M), .DAB(DAB), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN),
        .P(p_a), .PCOUT(pcout_a), .CARRYOUT(co_a), .CARRYOUTF(cof_a)
    );

    dsp_post_adder_acc #(
        .PREG(1'b0), .CARRYOUTREG(1'b0), .OPMODEREG(1'b0)
    ) dut_b (
        .CLK(CLK), .RST(RST), .CEP(CEP), .CEOPMODE(CEOPMODE), .CECARRYIN(CECARRYIN),
        .OPMODE(OPMODE), .M(M), .DAB(DAB), .C(C), .PCIN(PCIN), .CARRYIN(CARRYIN),
        .P(p_b), .PCOUT(pcout_b), .CARRYOUT(co_b), .CARRYOUTF(cof_b)
    );

    function automatic logic [48:0] alu(input logic [7:0] op, input logic ci,
                                        input logic [47:0] acc);
        logic [48:0] x, z;
        case (op[1:0])
            2'd0: x = 49'd0;
            2'd1: x = {13'd0, M};
            2'd2: x = {1'b0, acc};
            default: x = {1'b0, DAB};
        endcase
        case (op[3:2])
            2'd0: z = 49'd0;
            2'd1: z = {1'b0, PCIN};
            2'd2: z = {1'b0, acc};
            default: z = {1'b0, C};
        endcase
        if (op[7]) return z - x - {48'd0, ci};
        return z + x + {48'd0, ci};
    endfunction

    always @(posedge CLK or posedge RST) begin
        logic [48:0] ra, rb;
        if (RST) begin
            ma_p = '0; ma_co = 1'b0; ma_op = '0; ma_ci = 1'b0;
            mb_p = '0; mb_co = 1'b0; mb_ci = 1'b0;
        end else begin
            ra = alu(ma_op, ma_ci, ma_p);
            rb = alu(OPMODE, mb_ci, mb_p);
            if (CEP) begin
                ma_p = ra[47:0]; ma_co = ra[48];
                mb_p = rb[47:0]; mb_co = rb[48];
            end
            if (CEOPMODE) ma_op = OPMODE;
            if (CECARRYIN) begin
                ma_ci = OPMODE[5];
                mb_ci = OPMODE[5];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        logic [48:0] rb;
        if (started) begin
            rb = alu(OPMODE, mb_ci, mb_p);
            chk("model_p_a", {16'd0, p_a}, {16'd0, ma_p});
            chk("model_pcout_a", {16'd0, pcout_a}, {16'd0, ma_p});
            chk("model_co_a", {63'd0, co_a}, {63'd0, ma_co});
            chk("model_cof_a", {63'd0, cof_a}, {63'd0, ma_co});
            chk("model_p_b", {16'd0, p_b}, {16'd0, rb[47:0]});
            chk("model_pcout_b", {16'd0, pcout_b}, {16'd0, rb[47:0]});
            chk("model_co_b", {63'd0, co_b}, {63'd0, rb[48]});
            chk("model_cof_b", {63'd0, cof_b}, {63'd0, rb[48]});
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        #2 started = 1'b1;
        step(2);
        RST = 1'b0;
        chk("reset_p", {16'd0, p_a}, 64'd0);

        // Load 0x123 into P, then reset asynchronously mid-cycle
        DAB = 48'h123; OPMODE = 8'h03;
        step(2);
        chk("load_p", {16'd0, p_a}, 64'h123);
        #2 RST = 1'b1;
        #1;
        chk("async_rst_p", {16'd0, p_a}, 64'd0);
        chk("async_rst_co", {63'd0, co_a}, 64'd0);
        chk("async_rst_comb_p_b", {16'd0, p_b}, 64'h123);
        @(posedge CLK); #1;
        RST = 1'b0;

        // Multiply-accumulate: opmode takes one cycle to reach the adder
        OPMODE = 8'h09; M = 36'd5;
        step(2);
        chk("mac_5", {16'd0, p_a}, 64'd5);
        step(1);
        chk("mac_10", {16'd0, p_a}, 64'd10);
        step(1);
        chk("mac_15", {16'd0, p_a}, 64'd15);

        // Subtract with borrow
        C = 48'd3; DAB = 48'd5; OPMODE = 8'h8D;
        step(1);
        chk("sub_pre", {16'd0, p_a}, 64'd20);
        step(1);
        chk("sub_p", {16'd0, p_a}, 64'hFFFF_FFFF_FFFE);
        chk("sub_borrow", {63'd0, co_a}, 64'd1);

        // Wrap-around with carry-in from OPMODE[5]
        C = 48'hFFFF_FFFF_FFFF; OPMODE = 8'h2C;
        step(1);
        chk("wrap_pre_co", {63'd0, co_a}, 64'd0);
        step(1);
        chk("wrap_p", {16'd0, p_a}, 64'd0);
        chk("wrap_co", {63'd0, co_a}, 64'd1);

        // Clock enable hold and resume
        OPMODE = 8'h01; M = 36'd5;
        step(2);
        chk("ce_base", {16'd0, p_a}, 64'd5);
        CEP = 1'b0; M = 36'd9;
        step(2);
        chk("ce_hold", {16'd0, p_a}, 64'd5);
        CEP = 1'b1;
        step(1);
        chk("ce_resume", {16'd0, p_a}, 64'd9);
        chk("ce_resume_co", {63'd0, co_a}, 64'd0);

        // Bypassed instance: PCIN passes straight through, even under reset
        OPMODE = 8'h04; PCIN = 48'h0ABC;
        #1;
        chk("bypass_p_b", {16'd0, p_b}, 64'h0ABC);
        chk("bypass_pcout_b", {16'd0, pcout_b}, 64'h0ABC);
        RST = 1'b1;
        #1;
        chk("bypass_rst_p_b", {16'd0, p_b}, 64'h0ABC);
        chk("bypass_rst_p_a", {16'd0, p_a}, 64'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // X = Z = P gives 2*P + ci
        DAB = 48'd7; OPMODE = 8'h03;
        step(2);
        chk("dbl_base", {16'd0, p_a}, 64'd7);
        OPMODE = 8'h2A;
        step(2);
        chk("dbl_p", {16'd0, p_a}, 64'd15);
        step(1);
        chk("dbl_p2", {16'd0, p_a}, 64'd31);
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
